// File: rtl/iter_func_pkg.sv
// Shared types and constants for the iterative function unit.
package iter_func_pkg;

  typedef enum logic [1:0] {
    OP_DBL  = 2'd0,
    OP_MULX = 2'd1,
    OP_CAT  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CAT_LO_W       = 16;
  localparam int MULX_FLIP_MASK = 1;

endpackage

// File: rtl/iter_func_unit_if.sv
// Operand-in / result-out stream bundle for iter_func_unit.
interface iter_func_unit_if #(
  parameter int NUM_W = 32,
  parameter int RND_W = 5
);
  // Both streams use valid/ready: a beat transfers on a rising clk edge where
  // valid && ready; once valid is raised the sender holds payload and valid
  // stable until that edge, and ready may change freely.
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [RND_W-1:0] in_rounds;
  logic [NUM_W-1:0] in_num;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] out_data;

  modport master (
    output in_valid, in_op, in_rounds, in_num, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_rounds, in_num, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/iter_func_step.sv
// One combinational iteration: a doubling step or one shift-add multiply step.
module iter_func_step
  import iter_func_pkg::*;
#(
  parameter int NUM_W = 32
) (
  input  op_e              op,
  input  logic [NUM_W-1:0] acc,
  input  logic [NUM_W-1:0] mcand,
  input  logic             mbit,
  output logic [NUM_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    case (op)
      OP_DBL:  acc_next = acc << 1;
      OP_MULX: acc_next = mbit ? (acc + mcand) : acc;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/iter_func_unit.sv
// Sequential evaluator: repeated doubling, bit-tweaked multiply, concatenation,
// pass-through. One tuple in flight; result held in DONE until taken.
module iter_func_unit
  import iter_func_pkg::*;
#(
  parameter int NUM_W = 32,
  parameter int RND_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  iter_func_unit_if.slave   bus,
  output state_e            dbg_state
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [NUM_W-1:0] acc_q, acc_d;
  logic [NUM_W-1:0] mcand_q, mcand_d;
  logic [RND_W-1:0] mplier_q, mplier_d;
  logic [RND_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] out_data_q, out_data_d;
  logic [NUM_W-1:0] acc_next;

  iter_func_step #(.NUM_W(NUM_W)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .mcand    (mcand_q),
    .mbit     (mplier_q[0]),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = op_e'(bus.in_op);
          case (op_e'(bus.in_op))
            OP_DBL: begin
              acc_d = bus.in_num;
              cnt_d = bus.in_rounds;
              if (bus.in_rounds == '0) begin
                out_data_d = bus.in_num;
                state_d    = DONE;
              end else begin
                state_d = RUN;
              end
            end
            OP_MULX: begin
              // Multiplier is rounds with bit0 flipped, consumed LSB first.
              acc_d    = '0;
              mcand_d  = bus.in_num;
              mplier_d = bus.in_rounds ^ RND_W'(MULX_FLIP_MASK);
              cnt_d    = RND_W'(RND_W);
              state_d  = RUN;
            end
            OP_CAT: begin
              out_data_d = NUM_W'({bus.in_num[CAT_LO_W-1:0], bus.in_rounds[0]});
              state_d    = DONE;
            end
            default: begin
              out_data_d = bus.in_num;
              state_d    = DONE;
            end
          endcase
        end
      end
      RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == RND_W'(1)) begin
          out_data_d = acc_next;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_DBL;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_iter_func_unit.sv
// Directed and randomized bench for iter_func_unit against an arithmetic model.
module tb_iter_func_unit;
  import iter_func_pkg::*;

  localparam int NUM_W = 32;
  localparam int RND_W = 5;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;
  always #5 clk = ~clk;

  iter_func_unit_if #(.NUM_W(NUM_W), .RND_W(RND_W)) bus ();

  iter_func_unit #(.NUM_W(NUM_W), .RND_W(RND_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [NUM_W-1:0] exp_q[$];
  int               lat_q[$];

  function automatic logic [NUM_W-1:0] ref_result(input logic [1:0] op,
                                                   input logic [RND_W-1:0] r,
                                                   input logic [NUM_W-1:0] n);
    longint unsigned a, b;
    a = n;
    b = r;
    case (op)
      2'd0:    return NUM_W'(a * (64'd1 << b));
      2'd1:    return NUM_W'(a * (b ^ 64'd1));
      2'd2:    return NUM_W'((a % 65536) * 2 + (b % 2));
      default: return n;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [RND_W-1:0] r);
    if (op == 2'd0) return (r == 0) ? 1 : int'(r) + 1;
    if (op == 2'd1) return RND_W + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [NUM_W-1:0] obs,
                     input logic [NUM_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [RND_W-1:0] r,
                      input logic [NUM_W-1:0] n);
    int guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rounds = r;
    bus.in_num    = n;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(ref_result(op, r, n));
    lat_q.push_back(ref_latency(op, r));
  endtask

  task automatic recv(input int hold, input string tag);
    int lat = 1;
    int elat;
    logic [NUM_W-1:0] exp;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_data"}, bus.out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_data"}, bus.out_data, exp);
      chk({tag, "_hold_busy"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_rounds = '0;
    bus.in_num    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(2'd0, 5'd3, 32'd2);             recv(0, "dbl_3");
    send(2'd1, 5'd3, 32'd2);             recv(0, "mulx_3");
    send(2'd1, 5'd0, 32'd7);             recv(0, "mulx_0");
    send(2'd2, 5'd0, 32'h0000_0002);     recv(0, "cat_0");
    send(2'd2, 5'd1, 32'hFFFF_8001);     recv(0, "cat_1");
    send(2'd0, 5'd0, 32'd64);            recv(0, "dbl_0");
    send(2'd0, 5'd31, 32'd3);            recv(0, "dbl_31_3");
    send(2'd0, 5'd31, 32'd1);            recv(0, "dbl_31_1");
    send(2'd3, 5'd9, 32'hDEAD_BEEF);     recv(0, "pass");
    send(2'd1, 5'd31, 32'hFFFF_FFFF);    recv(0, "mulx_max");

    // Second tuple presented while the first result is back-pressured.
    send(2'd1, 5'd7, 32'h0000_1234);
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'd3;
    bus.in_rounds = 5'd2;
    bus.in_num    = 32'hCAFE_F00D;
    recv(10, "bp");
    send(2'd3, 5'd2, 32'hCAFE_F00D);     recv(0, "bp_next");

    // Asynchronous reset in the middle of a multiply.
    send(2'd1, 5'd5, 32'd9);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("arst_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end
    send(2'd0, 5'd4, 32'd5);             recv(0, "arst_next");

    for (int i = 0; i < 30; i++) begin
      logic [1:0]       op;
      logic [RND_W-1:0] r;
      logic [NUM_W-1:0] n;
      op = 2'($urandom_range(0, 3));
      r  = RND_W'($urandom_range(0, 31));
      n  = $urandom;
      send(op, r, n);
      recv($urandom_range(0, 3), "rnd");
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
